uart_rx: RTL

//  Serial receive stage of the UART link; the counterpart of the transmit stage on the same line format.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side word port of the UART: one-entry valid/ready register plus error flags.
// master is the receiver driving the word, slave is the consumer.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_rdy;
    logic                  data_vld;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  par_err;
    logic                  frm_err;
    logic                  overrun;

    modport master (
        input  data_rdy,
        output data_vld,
        output data_out,
        output par_err,
        output frm_err,
        output overrun
    );

    modport slave (
        output data_rdy,
        input  data_vld,
        input  data_out,
        input  par_err,
        input  frm_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH bits LSB first, optional odd parity, one stop bit.
// Each completed frame lands in a one-entry valid/ready register with parity/framing/overrun flags.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on the synchronised input
// START  | counting to the middle of the start bit to reject glitches
// DATA   | sampling data bits at mid-bit
// PARITY | sampling the odd parity bit
// STOP   | sampling the stop bit, then completing the frame
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BR         = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int BR_DIV = CLK_FREQ / BR;
    localparam int HALF   = BR_DIV / 2;
    localparam int CW     = $clog2(BR_DIV);
    localparam int BW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] BR_LAST   = CW'(BR_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                  r_rx_m;
    logic                  r_rx_s;
    logic                  r_rx_d;
    logic [2:0]            r_state;
    logic [CW-1:0]         r_br_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bad;
    logic                  r_stop_bit;
    logic                  r_done;
    logic                  r_data_vld;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_par_err;
    logic                  r_frm_err;
    logic                  r_overrun;
    logic                  w_fall;
    logic                  w_bit_end;

    assign w_fall    = r_rx_d & ~r_rx_s;
    assign w_bit_end = (r_br_cnt == BR_LAST);

    // r_rx_d is the previous synchronised sample, used only for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_d <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
            r_rx_d <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_br_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bit <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_br_cnt <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_br_cnt == HALF_LAST) begin
                        r_br_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_par_bad <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_br_cnt <= r_br_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_br_cnt           <= '0;
                        r_shift[r_bit_cnt] <= r_rx_s;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_br_cnt <= r_br_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_br_cnt  <= '0;
                        r_par_bad <= (r_rx_s != ~^r_shift);
                        r_state   <= S_STOP;
                    end else begin
                        r_br_cnt <= r_br_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // complete at mid stop bit so a back-to-back start edge is not missed
                    if (w_bit_end) begin
                        r_br_cnt   <= '0;
                        r_stop_bit <= r_rx_s;
                        r_done     <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_br_cnt <= r_br_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_br_cnt <= '0;
                end
            endcase
        end
    end

    // a completing frame may load in the same cycle the held word is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_vld <= 1'b0;
            r_data_out <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_data_vld || bus.data_rdy) begin
                    r_data_vld <= 1'b1;
                    r_data_out <= r_shift;
                    r_par_err  <= r_par_bad;
                    r_frm_err  <= ~r_stop_bit;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_data_vld && bus.data_rdy) begin
                r_data_vld <= 1'b0;
            end
        end
    end

    assign bus.data_vld = r_data_vld;
    assign bus.data_out = r_data_out;
    assign bus.par_err  = r_par_err;
    assign bus.frm_err  = r_frm_err;
    assign bus.overrun  = r_overrun;
endmodule
